// File: rtl/scmp_useq_if.sv
// rtl/scmp_useq_if.sv - microword/status bundle between the control ROM side and the SC/MP microsequencer.
interface scmp_useq_if #(
  parameter int UPC_W = 8
);
  logic [2:0]       nxt_mode;
  logic [UPC_W-1:0] nxt_target;
  logic [1:0]       cond_sel;
  logic [3:0]       cond_flags;
  logic [UPC_W-1:0] disp_pc;
  logic             bus_done;
  logic             irq;
  logic             ie;
  logic             halt_req;
  logic             stall;
  logic [UPC_W-1:0] upc;
  logic             int_ack;
  logic             at_fetch;
  logic             halted;
  logic             stack_err;

  modport slave (
    input  nxt_mode, nxt_target, cond_sel, cond_flags, disp_pc,
    input  bus_done, irq, ie, halt_req, stall,
    output upc, int_ack, at_fetch, halted, stack_err
  );

  modport master (
    output nxt_mode, nxt_target, cond_sel, cond_flags, disp_pc,
    output bus_done, irq, ie, halt_req, stall,
    input  upc, int_ack, at_fetch, halted, stack_err
  );
endinterface

// File: rtl/scmp_useq.sv
// rtl/scmp_useq.sv - SC/MP microcode program-counter sequencer.
// Selects the next upc per microword mode; handles interrupt entry, halt and a 2-deep return stack.
module scmp_useq #(
  parameter int UPC_W      = 8,
  parameter int RESET_ADDR = 0,
  parameter int FETCH_ADDR = 1,
  parameter int INT_ADDR   = 2
) (
  input  logic         clk,
  input  logic         rst,
  scmp_useq_if.slave   bus
);
  localparam logic [2:0] M_SEQ = 3'd0, M_JMP = 3'd1, M_DISP = 3'd2, M_BRC = 3'd3;
  localparam logic [2:0] M_WAIT = 3'd4, M_CALL = 3'd5, M_RET = 3'd6, M_FETCH = 3'd7;
  localparam logic [UPC_W-1:0] ONE     = UPC_W'(1);
  localparam logic [UPC_W-1:0] RESET_A = UPC_W'(RESET_ADDR);
  localparam logic [UPC_W-1:0] FETCH_A = UPC_W'(FETCH_ADDR);
  localparam logic [UPC_W-1:0] INT_A   = UPC_W'(INT_ADDR);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d, upc_inc;
  logic [1:0]       depth_q, depth_d;
  logic [UPC_W-1:0] stk_q [2];
  logic [UPC_W-1:0] stk_d [2];
  logic             int_ack_q, int_ack_d;
  logic             stack_err_q, stack_err_d;

  assign upc_inc = upc_q + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      upc_q       <= RESET_A;
      depth_q     <= 2'd0;
      stk_q[0]    <= '0;
      stk_q[1]    <= '0;
      int_ack_q   <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      depth_q     <= depth_d;
      stk_q       <= stk_d;
      int_ack_q   <= int_ack_d;
      stack_err_q <= stack_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    depth_d     = depth_q;
    stk_d       = stk_q;
    int_ack_d   = 1'b0;
    stack_err_d = stack_err_q;
    if (!bus.stall) begin
      if (state_q == HALT) begin
        // Resuming only re-enters RUN; the irq check waits for the next FETCH word.
        upc_d = FETCH_A;
        if (!bus.halt_req) state_d = RUN;
      end else begin
        case (bus.nxt_mode)
          M_SEQ:  upc_d = upc_inc;
          M_JMP:  upc_d = bus.nxt_target;
          M_DISP: upc_d = bus.disp_pc;
          M_BRC:  upc_d = bus.cond_flags[bus.cond_sel] ? bus.nxt_target : upc_inc;
          M_WAIT: upc_d = bus.bus_done ? upc_inc : upc_q;
          M_CALL: begin
            upc_d = bus.nxt_target;
            if (depth_q == 2'd0) begin
              stk_d[0] = upc_inc;
              depth_d  = 2'd1;
            end else if (depth_q == 2'd1) begin
              stk_d[1] = upc_inc;
              depth_d  = 2'd2;
            end else begin
              stack_err_d = 1'b1;
            end
          end
          M_RET: begin
            if (depth_q == 2'd2) begin
              upc_d   = stk_q[1];
              depth_d = 2'd1;
            end else if (depth_q == 2'd1) begin
              upc_d   = stk_q[0];
              depth_d = 2'd0;
            end else begin
              upc_d       = FETCH_A;
              stack_err_d = 1'b1;
            end
          end
          M_FETCH: begin
            depth_d = 2'd0;
            if (bus.halt_req) begin
              state_d = HALT;
              upc_d   = FETCH_A;
            end else if (bus.irq && bus.ie) begin
              upc_d     = INT_A;
              int_ack_d = 1'b1;
            end else begin
              upc_d = FETCH_A;
            end
          end
          default: upc_d = upc_q;
        endcase
      end
    end
  end

  assign bus.upc       = upc_q;
  assign bus.int_ack   = int_ack_q;
  assign bus.at_fetch  = (upc_q == FETCH_A) && (state_q == RUN);
  assign bus.halted    = (state_q == HALT);
  assign bus.stack_err = stack_err_q;
endmodule

// File: doc/scmp_useq.md
Name: scmp_useq

Overview:
- Microcode program-counter sequencer for the SC/MP core.
- Holds the microcode address (upc) that drives the microcode ROM.
- Each cycle, picks the next upc from the current microword's next-address mode: sequential, jump, opcode dispatch, conditional branch, bus wait, call/return, or fetch.
- Adds interrupt entry at instruction boundaries, a halt state, and a 2-deep micro-return stack.

Parameters:
- UPC_W, 8, microcode address width.
- RESET_ADDR, 0, upc after reset.
- FETCH_ADDR, 1, instruction-fetch microroutine entry.
- INT_ADDR, 2, interrupt microroutine entry.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- nxt_mode  in  3  microword next-address mode: 0 SEQ, 1 JMP, 2 DISP, 3 BRC, 4 WAIT, 5 CALL, 6 RET, 7 FETCH.
- nxt_target  in  UPC_W  microword target for JMP/BRC/CALL.
- cond_sel  in  2  selects a bit of cond_flags for BRC.
- cond_flags  in  4  datapath flags (0 CY, 1 OV, 2 AC zero, 3 sense B).
- disp_pc  in  UPC_W  entry label decoded from the opcode register.
- bus_done  in  1  external bus cycle complete.
- irq  in  1  interrupt request (sense A).
- ie  in  1  interrupt enable.
- halt_req  in  1  halt at next instruction boundary.
- stall  in  1  freeze the sequencer this cycle.
- upc  out  UPC_W  current microcode address.
- int_ack  out  1  one-cycle pulse when the interrupt entry is taken.
- at_fetch  out  1  high when upc == FETCH_ADDR and state is RUN.
- halted  out  1  high in HALT state.
- stack_err  out  1  sticky flag: micro-stack overflow or underflow.

Behaviour:
- Reset (async): upc=RESET_ADDR, state=RUN, stack depth=0, int_ack=0, halted=0, stack_err=0. Reset asserted mid-routine aborts it immediately; no stack contents survive.
- States: RUN, HALT.
- Timing: the ROM is combinational, so nxt_* reflect the word at the current upc. The new upc registers on the next rising edge (1-cycle latency per microword).
- stall=1: upc, state, stack and flags hold; int_ack=0. stall has priority over everything except rst.
- RUN next upc by mode:
  - SEQ: upc+1, wrapping modulo 2^UPC_W.
  - JMP: nxt_target.
  - DISP: disp_pc.
  - BRC: nxt_target if cond_flags[cond_sel], else upc+1.
  - WAIT: upc holds while bus_done=0; upc+1 when bus_done=1.
  - CALL: push upc+1, go to nxt_target. At depth 2, the push is dropped, the jump still occurs and stack_err is set.
  - RET: pop to the top entry. At depth 0, go to FETCH_ADDR and set stack_err.
  - FETCH (instruction boundary), priority order:
    1. halt_req=1 → HALT; upc=FETCH_ADDR.
    2. irq & ie → upc=INT_ADDR, int_ack=1 for exactly that cycle.
    3. Otherwise upc=FETCH_ADDR.
  - FETCH also clears stack depth to 0; stack_err stays sticky.
- HALT:
  - upc holds at FETCH_ADDR, halted=1; irq is ignored.
  - When halt_req=0, the next edge returns to RUN. The FETCH-boundary evaluation (irq check included) happens on the following FETCH microword.
- int_ack is registered and is high only in the cycle after the edge that loaded INT_ADDR.
- The micro-stack is LIFO. Depth counts 0..2; pushes and pops are single-cycle.

Test Plan:
- Reset, then free-run with nxt_mode=SEQ → upc 0,1,2,…; with UPC_W=8, after 255 the upc wraps to 0.
- nxt_mode=DISP, disp_pc=8'h40 → upc=8'h40 next edge. BRC target 8'h10 with cond_sel=0: CY=1 → upc 8'h10; CY=0 → upc+1.
- WAIT at upc 8'h20 with bus_done low for 3 cycles → upc stays 8'h20 for 3 edges, then becomes 8'h21 the edge after bus_done=1. stall asserted in the middle → no change.
- CALL to 8'h30 from 8'h05, then CALL to 8'h50 from 8'h31, then RET, RET → upc 8'h30, 8'h50, 8'h32, 8'h06. A third nested CALL sets stack_err. A RET at depth 0 → upc=FETCH_ADDR and stack_err=1.
- FETCH with irq=1, ie=1 → upc=INT_ADDR, int_ack pulses one cycle. With ie=0 → upc=FETCH_ADDR, no int_ack.
- halt_req=1 and irq=1 at a FETCH word → HALT, halted=1, no int_ack. After halt_req drops → RUN, and the next FETCH word takes the interrupt. Asserting rst during HALT → upc=0, halted=0 immediately.
